// File: rtl/memory.sv
// rtl/memory.sv - instruction/data storage for the 24-bit RISC CPU
// DATA_INIT_EN: when defined, dmem[i] starts at i; otherwise all entries start at 0.
module memory #(
  parameter int WIDTH   = 24,
  parameter int IMEM_AW = 15,
  parameter int DMEM_AW = 8
) (
  input  logic               mem_clk,
  input  logic               mem_rst,
  input  logic [WIDTH-1:0]   instruction_code,
  input  logic [WIDTH-1:0]   data_in_mem,
  input  logic [IMEM_AW-1:0] mem_PC,
  input  logic               we_store_mem,
  input  logic               we_load_mem,
  output logic [WIDTH-1:0]   data_out_Instr,
  output logic [WIDTH-1:0]   data_out_Data
);

  localparam int IMEM_DEPTH = 1 << IMEM_AW;
  localparam int DMEM_DEPTH = 1 << DMEM_AW;

  localparam logic [3:0] OP_LD = 4'b1010;
  localparam logic [3:0] OP_ST = 4'b1011;

  logic [WIDTH-1:0] imem [IMEM_DEPTH];
  logic [WIDTH-1:0] dmem [DMEM_DEPTH];

  logic [3:0]         opcode;
  logic [DMEM_AW-1:0] daddr;
  logic               do_store;
  logic               do_load;

  // High address-field bits are dropped, so data addresses alias modulo the dmem depth.
  assign opcode   = instruction_code[23:20];
  assign daddr    = instruction_code[DMEM_AW+3:4];
  assign do_store = we_store_mem && (opcode == OP_ST);
  assign do_load  = we_load_mem  && (opcode == OP_LD);

  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      imem[i] = '0;
    end
    for (int i = 0; i < DMEM_DEPTH; i++) begin
`ifdef DATA_INIT_EN
      dmem[i] = WIDTH'(i);
`else
      dmem[i] = '0;
`endif
    end
  end

  // Storage is not cleared by reset; an edge seen during reset simply writes nothing.
  always_ff @(posedge mem_clk) begin
    if (!mem_rst) begin
      imem[mem_PC] <= instruction_code;
      if (do_store) begin
        dmem[daddr] <= data_in_mem;
      end
    end
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      data_out_Instr <= '0;
      data_out_Data  <= '0;
    end else begin
      data_out_Instr <= instruction_code;
      if (do_load) begin
        data_out_Data <= dmem[daddr];
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed self-checking bench for memory
module tb_memory;

  logic        mem_clk = 1'b0;
  logic        mem_rst = 1'b1;
  logic [23:0] instruction_code = '0;
  logic [23:0] data_in_mem = '0;
  logic [14:0] mem_PC = '0;
  logic        we_store_mem = 1'b0;
  logic        we_load_mem = 1'b0;
  logic [23:0] data_out_Instr;
  logic [23:0] data_out_Data;

  int checks = 0;
  int errors = 0;

  memory dut (
    .mem_clk          (mem_clk),
    .mem_rst          (mem_rst),
    .instruction_code (instruction_code),
    .data_in_mem      (data_in_mem),
    .mem_PC           (mem_PC),
    .we_store_mem     (we_store_mem),
    .we_load_mem      (we_load_mem),
    .data_out_Instr   (data_out_Instr),
    .data_out_Data    (data_out_Data)
  );

  always #5 mem_clk = ~mem_clk;

  function automatic logic [23:0] init_val(input int i);
`ifdef DATA_INIT_EN
    return 24'(i);
`else
    return 24'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %06h expected %06h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [23:0] ic, input logic [23:0] din, input logic [14:0] pc,
                      input logic st, input logic ld);
    instruction_code = ic;
    data_in_mem      = din;
    mem_PC           = pc;
    we_store_mem     = st;
    we_load_mem      = ld;
    @(posedge mem_clk);
    #1;
  endtask

  initial begin
    #1;
    check("reset_instr", data_out_Instr, 24'h0);
    check("reset_data", data_out_Data, 24'h0);
    @(negedge mem_clk);
    mem_rst = 1'b0;

    step(24'hA00011, 24'h0, 15'd0, 1'b0, 1'b1);
    check("init_load", data_out_Data, init_val(1));
    check("init_load_instr", data_out_Instr, 24'hA00011);

    step(24'hB000A3, 24'h00FFFF, 15'd1, 1'b0, 1'b0);
    check("gated_st_instr", data_out_Instr, 24'hB000A3);
    step(24'hA000AA, 24'h0, 15'd2, 1'b0, 1'b1);
    check("gated_st_load", data_out_Data, init_val(10));

    step(24'hB000A3, 24'h000123, 15'd3, 1'b1, 1'b1);
    check("st_both_en_hold", data_out_Data, init_val(10));
    step(24'hA000AA, 24'h0, 15'd4, 1'b0, 1'b1);
    check("raw_load", data_out_Data, 24'h000123);

    step(24'h0300A2, 24'h000555, 15'd5, 1'b1, 1'b0);
    step(24'hA000AA, 24'h0, 15'd6, 1'b0, 1'b1);
    check("non_st_opcode_no_write", data_out_Data, 24'h000123);

    step(24'h030102, 24'h0, 15'd2, 1'b0, 1'b1);
    check("alu_instr", data_out_Instr, 24'h030102);
    check("alu_data_hold", data_out_Data, 24'h000123);

    step(24'hB010A3, 24'h0000AB, 15'd7, 1'b1, 1'b0);
    step(24'hA000AA, 24'h0, 15'd8, 1'b0, 1'b1);
    check("alias_load", data_out_Data, 24'h0000AB);

    #2;
    mem_rst = 1'b1;
    #1;
    check("async_rst_instr", data_out_Instr, 24'h0);
    check("async_rst_data", data_out_Data, 24'h0);
    step(24'hB00053, 24'h000777, 15'd9, 1'b1, 1'b0);
    check("rst_edge_instr", data_out_Instr, 24'h0);
    step(24'hA00050, 24'h0, 15'd10, 1'b0, 1'b1);
    check("rst_edge_data", data_out_Data, 24'h0);
    mem_rst = 1'b0;
    step(24'hA00050, 24'h0, 15'd10, 1'b0, 1'b1);
    check("st_in_rst_dropped", data_out_Data, init_val(5));
    check("post_rst_instr", data_out_Instr, 24'hA00050);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
